// File: rtl/bcd_pkg.sv
// Shared BCD / Excess-3 constants and digit helpers.
package bcd_pkg;
  localparam int DIGIT_W        = 4;
  localparam int BITS_PER_DIGIT = 4;
  localparam int BCD_MAX        = 9;
  localparam int EXCESS3_OFFSET = 3;
  localparam int EXCESS3_MAX    = BCD_MAX + EXCESS3_OFFSET;
  localparam int BIT_IDX_W      = $clog2(BITS_PER_DIGIT);

  typedef logic [DIGIT_W-1:0] digit_t;

  function automatic logic is_bcd(input digit_t d);
    return d <= digit_t'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_digit_fifo.sv
// Digit FIFO, DEPTH entries (power of 2, >= 2); head readable combinationally, pop/push take effect on the edge.
// Backpressure: push ignored when full, pop ignored when empty; extra pointer bit separates full from empty.
module bcd_digit_fifo
  import bcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  digit_t push_dat,
  input  logic   pop,
  output digit_t pop_dat,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  digit_t      mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/bcd_serializer.sv
// Parallel BCD digits -> LSB-first bit stream in fixed 4-clock frames; padding frames when idle, digits wait <=4 clocks for a boundary.
// din_ready = FIFO not full. Define BCD_SERIALIZER_CHECK_EN to drop digits > 9 and pulse err.
module bcd_serializer
  import bcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIGIT_W-1:0]   din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 x,
  output logic                 bit_valid,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 err
);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BITS_PER_DIGIT - 1);

  logic [BIT_IDX_W-1:0] cnt_q, cnt_d;
  digit_t               sr_q, sr_d;
  logic                 active_q, active_d;
  logic                 err_q, err_d;

  logic   xfer;
  logic   push;
  logic   pop;
  logic   boundary;
  digit_t head;
  logic   fifo_full;
  logic   fifo_empty;

  assign xfer     = din_valid && din_ready;
  assign boundary = (cnt_q == LAST_BIT);
  assign pop      = boundary && !fifo_empty;

`ifdef BCD_SERIALIZER_CHECK_EN
  assign push  = xfer && is_bcd(din);
  assign err_d = xfer && !is_bcd(din);
`else
  assign push  = xfer;
  assign err_d = 1'b0;
`endif

  bcd_digit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .push_dat(din),
    .pop     (pop),
    .pop_dat (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Framing never stalls: an empty FIFO at a boundary yields a zero padding digit.
  always_comb begin
    cnt_d    = cnt_q + BIT_IDX_W'(1);
    sr_d     = sr_q >> 1;
    active_d = active_q;
    if (boundary) begin
      sr_d     = fifo_empty ? '0 : head;
      active_d = !fifo_empty;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      sr_q     <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign din_ready = !fifo_full;
  assign x         = sr_q[0];
  assign bit_valid = active_q;
  assign bit_idx   = cnt_q;
  assign err       = err_q;
endmodule

// File: tb/tb_bcd_serializer.sv
// Directed bench for bcd_serializer: cycle table plus full-FIFO and Excess-3 end-to-end streams.
module tb_bcd_serializer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = 4'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       x;
  logic       bit_valid;
  logic [1:0] bit_idx;
  logic       err;

`ifdef BCD_SERIALIZER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  bcd_serializer #(.DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .x        (x),
    .bit_valid(bit_valid),
    .bit_idx  (bit_idx),
    .err      (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] din;
    logic       x;
    logic       bv;
    logic [1:0] idx;
    logic       rdy;
    logic       err;
    logic       chk;
  } vec_t;

  vec_t vecs[$];
  int   fill_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  int   cur_step = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, cur_step, act, exp);
    end
  endtask

  // Expected bit_idx comes from a free-running model counter cleared by reset rows.
  task automatic add(input logic rst, input logic vld, input logic [3:0] d,
                     input logic ex, input logic ebv, input logic erdy, input logic eerr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.din = d;
    v.x = ex; v.bv = ebv; v.rdy = erdy; v.err = eerr;
    v.idx = 2'(fill_cnt);
    v.chk = (vecs.size() != 0);
    vecs.push_back(v);
    fill_cnt = rst ? 0 : (fill_cnt + 1) % 4;
  endtask

  task automatic add_digit(input logic [3:0] d, input logic bv);
    for (int i = 0; i < 4; i++) add(0, 0, 0, bv & d[i], bv, 1, 0);
  endtask

  task automatic fill_table();
    logic [3:0] d12;
    d12 = 4'd12;
    add(1, 1, 7, 0, 0, 1, 0);            // reset row, din_valid ignored
    add(0, 1, 5, 0, 0, 1, 0);            // push 5 on first cycle
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 9, 1, 1, 1, 0);            // digit 5 bits 1,0,1,0 while pushing 9,0,3
    add(0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 3, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0);
    add_digit(4'd9, 1);
    add_digit(4'd0, 1);
    add_digit(4'd3, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0);            // idx 2
    add(0, 1, 2, 0, 0, 1, 0);            // idx 3: pops 1
    add(0, 1, 4, 1, 1, 1, 0);            // digit 1 bit0
    add(0, 1, 6, 0, 1, 1, 0);            // 3 queued after this edge
    add(1, 1, 8, 0, 1, 1, 0);            // reset at idx 2
    add(0, 1, 7, 0, 0, 1, 0);            // everything cleared, push 7
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 0);
    add_digit(4'd7, 1);
    add(0, 0, 0, 0, 0, 1, 0);            // discarded digits never appear
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 12, 0, 0, 1, 0);           // non-BCD pushed on a boundary into empty FIFO
    add(0, 0, 0, 0, 0, 1, CHK);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, !CHK & d12[i], !CHK, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    din_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Streams src through the DUT, holding din_valid while digits remain; a downstream
  // serial add-3 stage model produces z from x so each digit's Excess-3 code is checked too.
  task automatic run_stream(input logic [3:0] src[$], input int budget, input bit chk_rdy,
                            input logic rdy_pat[13], input string tag);
    logic [3:0] got[$];
    logic [3:0] zgot[$];
    logic [3:0] dsh;
    logic [3:0] zsh;
    logic [1:0] sum;
    logic       carry;
    int pidx, first_bv, last_bv, bv_cycles;
    pidx = 0; first_bv = -1; last_bv = -1; bv_cycles = 0; carry = 1'b0;
    dsh = '0; zsh = '0;
    for (int c = 0; c < budget; c++) begin
      cur_step = c;
      if (chk_rdy && c < 13) check({tag, "_din_ready"}, 8'(din_ready), 8'(rdy_pat[c]));
      sum = 2'(x) + ((bit_idx < 2'd2) ? 2'd1 : 2'd0) + ((bit_idx == 2'd0) ? 2'd0 : 2'(carry));
      carry = sum[1];
      if (bit_valid) begin
        dsh[bit_idx] = x;
        zsh[bit_idx] = sum[0];
        if (first_bv < 0) first_bv = c;
        last_bv = c;
        bv_cycles++;
        if (bit_idx == 2'd3) begin
          got.push_back(dsh);
          zgot.push_back(zsh);
        end
      end
      if (got.size() == src.size()) break;
      din_valid = (pidx < src.size());
      din = din_valid ? src[pidx] : 4'd0;
      if (din_valid && din_ready) pidx++;
      @(negedge clock);
    end
    din_valid = 1'b0;
    check({tag, "_digit_count"}, 8'(got.size()), 8'(src.size()));
    for (int i = 0; i < got.size() && i < src.size(); i++) begin
      cur_step = i;
      check({tag, "_digit"}, 8'(got[i]), 8'(src[i]));
      check({tag, "_excess3"}, 8'(zgot[i]), 8'(src[i] + 4'd3));
    end
    check({tag, "_contiguous"}, 8'(last_bv - first_bv + 1), 8'(4 * src.size()));
    check({tag, "_bv_cycles"}, 8'(bv_cycles), 8'(4 * src.size()));
  endtask

  initial begin
    logic [3:0] src[$];
    logic       rdy_pat[13];
    logic       no_pat[13];

    fill_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      cur_step = i;
      if (vecs[i].chk) begin
        check("x", 8'(x), 8'(vecs[i].x));
        check("bit_valid", 8'(bit_valid), 8'(vecs[i].bv));
        check("bit_idx", 8'(bit_idx), 8'(vecs[i].idx));
        check("din_ready", 8'(din_ready), 8'(vecs[i].rdy));
        check("err", 8'(err), 8'(vecs[i].err));
      end
      reset     = vecs[i].rst;
      din_valid = vecs[i].vld;
      din       = vecs[i].din;
    end

    // Full FIFO: 5 digits accepted, ready low until one cycle after the next boundary pop.
    rdy_pat = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    src = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    run_stream(src, 60, 1'b1, rdy_pat, "full");

    no_pat = '{default: 1'b0};
    do_reset();
    src = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    run_stream(src, 120, 1'b0, no_pat, "e2e");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
